// File: rtl/sisc_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/ack, decode valid/ready,
// and branch redirect signals.
interface sisc_fetch_if #(
    parameter int unsigned PC_W = 16,
    parameter int unsigned IR_W = 32
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [IR_W-1:0] imem_rdata;
    logic [IR_W-1:0] ir;
    logic            ir_valid;
    logic            ir_ready;
    logic            br_taken;
    logic [PC_W-1:0] br_addr;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;

    modport master (
        output imem_req, imem_addr, ir, ir_valid, pc, pc_inc,
        input  imem_ack, imem_rdata, ir_ready, br_taken, br_addr
    );

    modport slave (
        input  imem_req, imem_addr, ir, ir_valid, pc, pc_inc,
        output imem_ack, imem_rdata, ir_ready, br_taken, br_addr
    );
endinterface

// File: rtl/sisc_fetch.sv
// SISC instruction fetch: owns the PC, fetches over req/ack into the instruction
// register, and hands it to decode over valid/ready; branch redirects squash wrong-path data.
module sisc_fetch #(
    parameter int unsigned     PC_W   = 16,
    parameter int unsigned     IR_W   = 32,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input logic         clk,
    input logic         rst_f,
    sisc_fetch_if.master bus
);
    typedef enum logic {StFetch, StFull} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] hold_addr_q, hold_addr_d;
    logic            squash_q, squash_d;
    logic            run_q;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [PC_W-1:0] pc_q, pc_d;

    logic req;
    logic ack;

    // run_q keeps imem_req low during reset and raises it on the first edge after release
    assign req = (state_q == StFetch) && run_q;
    assign ack = req && bus.imem_ack;

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_q     <= StFetch;
            fetch_pc_q  <= RST_PC;
            hold_addr_q <= RST_PC;
            squash_q    <= 1'b0;
            run_q       <= 1'b0;
            ir_q        <= '0;
            pc_q        <= RST_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            hold_addr_q <= hold_addr_d;
            squash_q    <= squash_d;
            run_q       <= 1'b1;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        hold_addr_d = hold_addr_q;
        squash_d    = squash_q;
        ir_d        = ir_q;
        pc_d        = pc_q;
        unique case (state_q)
            StFetch: begin
                if (ack) begin
                    squash_d = 1'b0;
                    if (!squash_q && !bus.br_taken) begin
                        ir_d       = bus.imem_rdata;
                        pc_d       = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 1'b1;
                        state_d    = StFull;
                    end
                end else if (req && bus.br_taken && !squash_q) begin
                    // Outstanding request must keep its address; remember it and drop the reply.
                    squash_d    = 1'b1;
                    hold_addr_d = fetch_pc_q;
                end
                if (bus.br_taken) begin
                    fetch_pc_d = bus.br_addr;
                end
            end
            StFull: begin
                if (bus.ir_ready || bus.br_taken) begin
                    state_d = StFetch;
                end
                if (bus.br_taken) begin
                    fetch_pc_d = bus.br_addr;
                end
            end
        endcase
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = squash_q ? hold_addr_q : fetch_pc_q;
    assign bus.ir        = ir_q;
    assign bus.ir_valid  = (state_q == StFull);
    assign bus.pc        = pc_q;
    assign bus.pc_inc    = pc_q + 1'b1;
endmodule
